// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller with occupancy count, thresholds,
// synchronous flush, sticky error flags and FWFT/registered read.
module fifo_sync_ctrl #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int FWFT      = 1,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             w_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             r_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_cfg
    $error("fifo_sync_ctrl: illegal DEPTH/AF_THRESH/AE_THRESH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic             live;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full    = (count == CW'(DEPTH));
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));
  assign push_ok      = w_valid & ~fifo_full;
  assign pop_ok       = r_ready & ~fifo_empty;
  assign live         = ~reset & ~flush;

  always_ff @(posedge clk) begin
    if (live && push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      unique case (1'b1)
        push_ok && !pop_ok: count <= count + 1'b1;
        pop_ok && !push_ok: count <= count - 1'b1;
        default: ;
      endcase
      if (w_valid && fifo_full)  overflow  <= 1'b1;
      if (r_ready && fifo_empty) underflow <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    logic [WIDTH-1:0] hold_q;

    // Last head word is kept so data_out is stable while empty.
    always_ff @(posedge clk) begin
      if (reset)            hold_q <= '0;
      else if (!fifo_empty) hold_q <= mem[rd_ptr];
    end

    assign data_out = fifo_empty ? hold_q : mem[rd_ptr];
    assign rd_valid = ~fifo_empty;
  end else begin : g_regrd
    logic [WIDTH-1:0] dout_q;
    logic             vld_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else if (flush) begin
        vld_q  <= 1'b0;
      end else begin
        vld_q <= pop_ok;
        if (pop_ok) dout_q <= mem[rd_ptr];
      end
    end

    assign data_out = dout_q;
    assign rd_valid = vld_q;
  end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl: DEPTH=4 FWFT and DEPTH=3 registered
// instances, directed scenarios plus a queue-model random soak.
module tb_fifo_sync_ctrl;

  logic       clk;
  logic       reset;
  logic       flush     [2];
  logic       w_valid   [2];
  logic [7:0] data_in   [2];
  logic       r_ready   [2];
  logic [7:0] data_out  [2];
  logic       rd_valid  [2];
  logic       full      [2];
  logic       empty     [2];
  logic       af        [2];
  logic       ae        [2];
  logic [2:0] cnt       [2];
  logic       ovf       [2];
  logic       udf       [2];

  int n_chk;
  int n_fail;

  logic [7:0] mq [2][$];
  logic       m_ovf  [2];
  logic       m_udf  [2];
  logic       m_rv   [2];
  logic [7:0] m_dout [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : 3;
    localparam int F = (g == 0) ? 1 : 0;
    localparam int C = $clog2(D + 1);
    logic [C-1:0] c;

    fifo_sync_ctrl #(.WIDTH(8), .DEPTH(D), .FWFT(F)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush[g]),
      .w_valid      (w_valid[g]),
      .data_in      (data_in[g]),
      .r_ready      (r_ready[g]),
      .data_out     (data_out[g]),
      .rd_valid     (rd_valid[g]),
      .fifo_full    (full[g]),
      .fifo_empty   (empty[g]),
      .almost_full  (af[g]),
      .almost_empty (ae[g]),
      .count        (c),
      .overflow     (ovf[g]),
      .underflow    (udf[g])
    );

    assign cnt[g] = 3'(c);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic bit fw(input int i);
    return (i == 0);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_ovf[i]  = 1'b0;
      m_udf[i]  = 1'b0;
      m_rv[i]   = 1'b0;
      m_dout[i] = 8'h00;
    end
  endtask

  // One clock of stimulus on instance i; the model follows the FIFO rules.
  task automatic tick(input int i, input logic wv, input logic [7:0] d,
                      input logic rr, input logic fl);
    int sz;
    logic pu, po;
    logic [7:0] x;
    w_valid[i] = wv;
    data_in[i] = d;
    r_ready[i] = rr;
    flush[i]   = fl;
    sz = mq[i].size();
    pu = wv && (sz < dep(i));
    po = rr && (sz > 0);
    @(posedge clk);
    if (fl) begin
      mq[i].delete();
      m_ovf[i] = 1'b0;
      m_udf[i] = 1'b0;
      m_rv[i]  = 1'b0;
    end else begin
      if (wv && sz == dep(i)) m_ovf[i] = 1'b1;
      if (rr && sz == 0)      m_udf[i] = 1'b1;
      m_rv[i] = po;
      if (po) begin
        x = mq[i].pop_front();
        if (!fw(i)) m_dout[i] = x;
      end
      if (pu) mq[i].push_back(d);
    end
    #1;
    w_valid[i] = 1'b0;
    r_ready[i] = 1'b0;
    flush[i]   = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (cnt[i] !== 3'd0) begin n_fail++; $display("FAIL reset_count[%0d]: got %0d want 0", i, cnt[i]); end
      n_chk++;
      if (empty[i] !== 1'b1 || full[i] !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full[%0d]: got %b%b want 10", i, empty[i], full[i]); end
      n_chk++;
      if (ae[i] !== 1'b1 || af[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ae_af[%0d]: got %b%b want 10", i, ae[i], af[i]); end
      n_chk++;
      if (rd_valid[i] !== 1'b0 || data_out[i] !== 8'h00) begin n_fail++; $display("FAIL reset_read[%0d]: got v=%b d=%h want v=0 d=00", i, rd_valid[i], data_out[i]); end
      n_chk++;
      if (ovf[i] !== 1'b0 || udf[i] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b%b want 00", i, ovf[i], udf[i]); end
    end
  endtask

  task automatic test_underflow();
    tick(0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_chk++;
    if (udf[0] !== 1'b1) begin n_fail++; $display("FAIL underflow_flag: got %b want 1", udf[0]); end
    n_chk++;
    if (cnt[0] !== 3'd0 || empty[0] !== 1'b1) begin n_fail++; $display("FAIL underflow_count: got %0d e=%b want 0 e=1", cnt[0], empty[0]); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(0, 1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0);
      n_chk++;
      if (cnt[0] !== 3'(k + 1)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", cnt[0], k + 1); end
      n_chk++;
      if (af[0] !== (k + 1 >= 3)) begin n_fail++; $display("FAIL fill_af: got %b at count %0d", af[0], k + 1); end
      n_chk++;
      if (full[0] !== (k == 3)) begin n_fail++; $display("FAIL fill_full: got %b at count %0d", full[0], k + 1); end
    end
    tick(0, 1'b1, 8'hA4, 1'b0, 1'b0);
    n_chk++;
    if (ovf[0] !== 1'b1 || cnt[0] !== 3'd4) begin n_fail++; $display("FAIL overflow: got ovf=%b cnt=%0d want 1 4", ovf[0], cnt[0]); end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (data_out[0] !== 8'hA0 + 8'(k) || rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL drain_data: got %h v=%b want %h v=1", data_out[0], rd_valid[0], 8'hA0 + 8'(k)); end
      tick(0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_chk++;
    if (empty[0] !== 1'b1 || cnt[0] !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got e=%b cnt=%0d want 1 0", empty[0], cnt[0]); end
  endtask

  task automatic test_simul();
    do_reset();
    tick(0, 1'b1, 8'h10, 1'b0, 1'b0);
    tick(0, 1'b1, 8'h11, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (data_out[0] !== 8'h10 + 8'(k)) begin n_fail++; $display("FAIL simul_data: got %h want %h", data_out[0], 8'h10 + 8'(k)); end
      tick(0, 1'b1, 8'h12, 1'b1, 1'b0);
      n_chk++;
      if (cnt[0] !== 3'd2) begin n_fail++; $display("FAIL simul_count: got %0d want 2", cnt[0]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    do_reset();
    tick(1, 1'b1, 8'h30, 1'b0, 1'b0);
    for (int n = 1; n <= 2; n++) begin
      for (int k = 0; k < 10; k++) begin
        d = 8'($urandom);
        tick(1, 1'b1, d, 1'b1, 1'b0);
        n_chk++;
        if (cnt[1] !== 3'(n)) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", cnt[1], n); end
        n_chk++;
        if (rd_valid[1] !== 1'b1 || data_out[1] !== m_dout[1]) begin n_fail++; $display("FAIL wrap_data: got %h v=%b want %h v=1", data_out[1], rd_valid[1], m_dout[1]); end
      end
      tick(1, 1'b1, 8'h31, 1'b0, 1'b0);
    end
  endtask

  task automatic test_registered();
    do_reset();
    tick(1, 1'b1, 8'h55, 1'b0, 1'b0);
    n_chk++;
    if (rd_valid[1] !== 1'b0) begin n_fail++; $display("FAIL reg_idle_valid: got %b want 0", rd_valid[1]); end
    tick(1, 1'b0, 8'h00, 1'b1, 1'b0);
    n_chk++;
    if (rd_valid[1] !== 1'b1 || data_out[1] !== 8'h55) begin n_fail++; $display("FAIL reg_pop: got v=%b d=%h want 1 55", rd_valid[1], data_out[1]); end
    tick(1, 1'b0, 8'h00, 1'b0, 1'b0);
    n_chk++;
    if (rd_valid[1] !== 1'b0 || data_out[1] !== 8'h55) begin n_fail++; $display("FAIL reg_hold: got v=%b d=%h want 0 55", rd_valid[1], data_out[1]); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 5; k++) tick(0, 1'b1, 8'h40 + 8'(k), 1'b0, 1'b0);
    tick(0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_chk++;
    if (cnt[0] !== 3'd3 || ovf[0] !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got cnt=%0d ovf=%b want 3 1", cnt[0], ovf[0]); end
    tick(0, 1'b1, 8'h77, 1'b0, 1'b1);
    n_chk++;
    if (cnt[0] !== 3'd0 || empty[0] !== 1'b1) begin n_fail++; $display("FAIL flush_count: got cnt=%0d e=%b want 0 1", cnt[0], empty[0]); end
    n_chk++;
    if (ovf[0] !== 1'b0 || rd_valid[0] !== 1'b0) begin n_fail++; $display("FAIL flush_flags: got ovf=%b v=%b want 0 0", ovf[0], rd_valid[0]); end
    tick(0, 1'b1, 8'h88, 1'b0, 1'b0);
    n_chk++;
    if (cnt[0] !== 3'd1 || data_out[0] !== 8'h88) begin n_fail++; $display("FAIL flush_nostore: got cnt=%0d d=%h want 1 88", cnt[0], data_out[0]); end
  endtask

  task automatic test_soak();
    int len, kind, sz;
    logic wv, rr, fl;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      for (int it = 0; it < 600; it++) begin
        len  = $urandom_range(0, 2 * dep(i));
        kind = $urandom_range(0, 2);
        for (int c = 0; c < len; c++) begin
          wv = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom_range(0, 1));
          rr = (kind == 1) ? 1'b1 : (kind == 0) ? 1'b0 : 1'($urandom_range(0, 1));
          fl = ($urandom_range(0, 99) == 0);
          tick(i, wv, 8'($urandom), rr, fl);
          sz = mq[i].size();
          n_chk++;
          if (cnt[i] !== 3'(sz)) begin n_fail++; $display("FAIL soak_count[%0d]: got %0d want %0d", i, cnt[i], sz); end
          n_chk++;
          if (empty[i] !== (sz == 0) || full[i] !== (sz == dep(i)) || af[i] !== (sz >= dep(i) - 1) || ae[i] !== (sz <= 1)) begin
            n_fail++; $display("FAIL soak_flags[%0d]: got e%b f%b af%b ae%b at size %0d", i, empty[i], full[i], af[i], ae[i], sz);
          end
          n_chk++;
          if (ovf[i] !== m_ovf[i] || udf[i] !== m_udf[i]) begin n_fail++; $display("FAIL soak_err[%0d]: got %b%b want %b%b", i, ovf[i], udf[i], m_ovf[i], m_udf[i]); end
          n_chk++;
          if (fw(i)) begin
            if (rd_valid[i] !== (sz > 0) || (sz > 0 && data_out[i] !== mq[i][0])) begin
              n_fail++; $display("FAIL soak_data[%0d]: got v=%b d=%h at size %0d", i, rd_valid[i], data_out[i], sz);
            end
          end else begin
            if (rd_valid[i] !== m_rv[i] || (m_rv[i] && data_out[i] !== m_dout[i])) begin
              n_fail++; $display("FAIL soak_data[%0d]: got v=%b d=%h want v=%b d=%h", i, rd_valid[i], data_out[i], m_rv[i], m_dout[i]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      flush[i]   = 1'b0;
      w_valid[i] = 1'b0;
      r_ready[i] = 1'b0;
      data_in[i] = 8'h00;
    end
    @(posedge clk);
    #1;
    do_reset();
    test_reset();
    test_underflow();
    test_fill_overflow();
    test_simul();
    test_wrap();
    test_registered();
    test_flush();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
